// File: rtl/ps2_rxfifo_funcmod.sv
`default_nettype none
// ============================================================================
// Module   : ps2_rxfifo_funcmod
// Purpose  : PS/2 device-to-host receiver with clock-line filtering, framing
//            and odd-parity checking, E0/F0 prefix folding and a show-ahead
//            FIFO of {tag, code} entries with a valid/read handshake.
// Ports    : CLOCK   - system clock
//            RESET   - synchronous reset, active-high
//            PS2_CLK - raw PS/2 clock line (asynchronous)
//            PS2_DAT - raw PS/2 data line (asynchronous)
//            iRead   - pop request, honoured only while oValid=1
//            oValid  - FIFO not empty
//            oData   - head entry scan code
//            oTag    - head entry tag {drop, parity err, framing err, 0,
//                      extended, break}
//            oCount  - number of entries held (0 .. 2**FIFO_AW)
// Revision : 1.0 - initial release
// ============================================================================
module ps2_rxfifo_funcmod #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 100000,
    parameter int FIFO_AW     = 3
) (
    input  logic               CLOCK,
    input  logic               RESET,
    input  logic               PS2_CLK,
    input  logic               PS2_DAT,
    input  logic               iRead,
    output logic               oValid,
    output logic [7:0]         oData,
    output logic [5:0]         oTag,
    output logic [FIFO_AW:0]   oCount
);

    localparam int               c_DEPTH = 1 << FIFO_AW;
    localparam int               c_TMR_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [FIFO_AW:0] c_FULL  = {1'b1, {FIFO_AW{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    // ---------------- input conditioning ----------------
    logic       r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic       r_flt;          // filtered PS/2 clock
    logic [7:0] r_flt_cnt;      // consecutive samples disagreeing with r_flt
    logic       r_fall;         // one-cycle strobe: filtered clock just fell
    logic       r_bit;          // data line captured with the edge

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_clk_s1  <= 1'b1;
            r_clk_s2  <= 1'b1;
            r_dat_s1  <= 1'b1;
            r_dat_s2  <= 1'b1;
            r_flt     <= 1'b1;
            r_flt_cnt <= 8'd0;
            r_fall    <= 1'b0;
            r_bit     <= 1'b0;
        end else begin
            r_clk_s1 <= PS2_CLK;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= PS2_DAT;
            r_dat_s2 <= r_dat_s1;
            r_fall   <= 1'b0;
            if (r_clk_s2 != r_flt) begin
                if (r_flt_cnt == 8'(FILTER_LEN - 1)) begin
                    r_flt     <= r_clk_s2;
                    r_flt_cnt <= 8'd0;
                    r_fall    <= r_flt;     // only a 1->0 flip is an edge
                    r_bit     <= r_dat_s2;
                end else begin
                    r_flt_cnt <= r_flt_cnt + 8'd1;
                end
            end else begin
                r_flt_cnt <= 8'd0;
            end
        end
    end

    // ---------------- frame FSM ----------------
    state_t               r_state, w_state_nxt;
    logic [7:0]           r_shift;
    logic [2:0]           r_bitcnt;
    logic                 r_par, r_stop, r_done;
    logic                 r_ext, r_brk, r_drop;
    logic [c_TMR_W-1:0]   r_timer;
    logic                 w_frame_end, w_active, w_timeout;

    // Timer guards both a stalled frame and a prefix byte with no follow-up.
    assign w_active  = (r_state != ST_IDLE) || r_ext || r_brk;
    assign w_timeout = w_active && !r_fall &&
                       (r_timer == c_TMR_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge CLOCK) begin
        if (RESET) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_frame_end = 1'b0;
        case (r_state)
            ST_IDLE:   if (r_fall && !r_bit) w_state_nxt = ST_DATA;
            ST_DATA:   if (r_fall && r_bitcnt == 3'd7) w_state_nxt = ST_PARITY;
            ST_PARITY: if (r_fall) w_state_nxt = ST_STOP;
            ST_STOP: begin
                if (r_fall) begin
                    w_state_nxt = ST_IDLE;
                    w_frame_end = 1'b1;
                end
            end
            default:   w_state_nxt = ST_IDLE;
        endcase
        if (w_timeout) begin
            w_state_nxt = ST_IDLE;
            w_frame_end = 1'b0;
        end
    end

    // ---------------- frame completion ----------------
    logic        w_par_err, w_frm_err, w_err, w_is_e0, w_is_f0, w_push;
    logic [13:0] w_entry;

    assign w_par_err = ~(^r_shift ^ r_par);
    assign w_frm_err = ~r_stop;
    assign w_err     = w_par_err | w_frm_err;
    assign w_is_e0   = (r_shift == 8'hE0);
    assign w_is_f0   = (r_shift == 8'hF0);
    assign w_push    = r_done && (w_err || !(w_is_e0 || w_is_f0));
    assign w_entry   = {r_drop, w_par_err, w_frm_err, 1'b0, r_ext, r_brk, r_shift};

    // ---------------- FIFO ----------------
    logic [13:0]        r_mem [c_DEPTH];
    logic [FIFO_AW-1:0] r_wptr, r_rptr;
    logic [FIFO_AW:0]   r_count;
    logic               w_pop, w_full, w_wr;

    assign w_pop  = iRead && (r_count != '0);
    assign w_full = (r_count == c_FULL);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_wr   = w_push && (!w_full || w_pop);

    always_ff @(posedge CLOCK) begin
        if (w_wr) r_mem[r_wptr] <= w_entry;
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_shift  <= 8'd0;
            r_bitcnt <= 3'd0;
            r_par    <= 1'b0;
            r_stop   <= 1'b0;
            r_done   <= 1'b0;
            r_ext    <= 1'b0;
            r_brk    <= 1'b0;
            r_drop   <= 1'b0;
            r_timer  <= '0;
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
        end else begin
            r_done <= w_frame_end;

            if (r_fall) begin
                case (r_state)
                    ST_IDLE:   r_bitcnt <= 3'd0;
                    ST_DATA: begin
                        r_shift  <= {r_bit, r_shift[7:1]};
                        r_bitcnt <= r_bitcnt + 3'd1;
                    end
                    ST_PARITY: r_par  <= r_bit;
                    ST_STOP:   r_stop <= r_bit;
                    default:   r_bitcnt <= 3'd0;
                endcase
            end

            if (!w_active || r_fall || w_timeout) r_timer <= '0;
            else                                  r_timer <= r_timer + c_TMR_W'(1);

            if (w_timeout) begin
                r_ext <= 1'b0;
                r_brk <= 1'b0;
            end else if (r_done) begin
                if (w_err || !(w_is_e0 || w_is_f0)) begin
                    r_ext <= 1'b0;
                    r_brk <= 1'b0;
                end else if (w_is_e0) begin
                    r_ext <= 1'b1;
                end else begin
                    r_brk <= 1'b1;
                end
            end

            if (w_push && !w_wr)  r_drop <= 1'b1;
            else if (w_wr)        r_drop <= 1'b0;

            if (w_wr)  r_wptr <= r_wptr + 1'b1;
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign oValid         = (r_count != '0);
    assign oCount         = r_count;
    assign {oTag, oData}  = oValid ? r_mem[r_rptr] : 14'd0;

endmodule
`default_nettype wire

// File: tb/tb_ps2_rxfifo_funcmod.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_rxfifo_funcmod
// Purpose  : Self-checking bench for ps2_rxfifo_funcmod. Expected entries are
//            queued when frames are sent; a monitor pops the FIFO and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_rxfifo_funcmod;

    localparam int FILTER_LEN  = 4;
    localparam int TIMEOUT_CYC = 2000;
    localparam int FIFO_AW     = 3;
    localparam int HALF        = 20;     // half PS/2 bit period in clocks

    logic             CLOCK = 1'b0;
    logic             RESET;
    logic             ps2_clk, ps2_dat;
    logic             mon_rd, tb_rd;
    logic             iRead;
    logic             oValid;
    logic [7:0]       oData;
    logic [5:0]       oTag;
    logic [FIFO_AW:0] oCount;

    int          n_total = 0;
    int          n_bad   = 0;
    int          rd_budget = 0;
    logic [13:0] q[$];

    assign iRead = mon_rd | tb_rd;

    always #5 CLOCK = ~CLOCK;

    ps2_rxfifo_funcmod #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .FIFO_AW    (FIFO_AW)
    ) dut (
        .CLOCK  (CLOCK),
        .RESET  (RESET),
        .PS2_CLK(ps2_clk),
        .PS2_DAT(ps2_dat),
        .iRead  (iRead),
        .oValid (oValid),
        .oData  (oData),
        .oTag   (oTag),
        .oCount (oCount)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, got, exp);
        end
    endtask

    // Monitor: pops up to rd_budget entries and compares each with the queue.
    initial begin
        mon_rd = 1'b0;
        forever begin
            @(negedge CLOCK);
            if (rd_budget > 0 && oValid && !RESET) begin
                if (q.size() == 0) begin
                    chk("unexpected_entry", {18'd0, oTag, oData}, 32'h0);
                end else begin
                    chk("entry", {18'd0, oTag, oData}, {18'd0, q.pop_front()});
                end
                mon_rd = 1'b1;
                rd_budget--;
            end else begin
                mon_rd = 1'b0;
            end
        end
    end

    // mode 1: check output latency after the stop fall
    // mode 2: pop the head in the same cycle the new entry is pushed
    task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stopb,
                              input int nbits, input int mode, input int rst_at);
        logic [10:0] bits;
        logic [13:0] e;
        bits = {stopb, (~^d) ^ par_flip, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                @(negedge CLOCK);
                RESET = 1'b1;
                @(negedge CLOCK);
                chk("rst_valid", {31'd0, oValid}, 32'd0);
                chk("rst_count", {28'd0, oCount}, 32'd0);
                chk("rst_tag",   {26'd0, oTag},   32'd0);
                RESET = 1'b0;
                q.delete();
            end
            @(negedge CLOCK);
            ps2_dat = bits[i];
            repeat (HALF) @(negedge CLOCK);
            ps2_clk = 1'b0;
            if (i == 10 && mode == 1) begin
                repeat (7) @(negedge CLOCK);
                chk("lat_valid_early", {31'd0, oValid}, 32'd0);
                @(negedge CLOCK);
                chk("lat_valid", {31'd0, oValid}, 32'd1);
                chk("lat_data",  {24'd0, oData},  {24'd0, d});
                chk("lat_tag",   {26'd0, oTag},   32'd0);
                chk("lat_count", {28'd0, oCount}, 32'd1);
                repeat (HALF - 8) @(negedge CLOCK);
            end else if (i == 10 && mode == 2) begin
                repeat (7) @(negedge CLOCK);
                tb_rd = 1'b1;
                if (q.size() == 0) chk("simul_head_missing", 32'd1, 32'd0);
                else begin
                    e = q.pop_front();
                    chk("simul_head", {18'd0, oTag, oData}, {18'd0, e});
                end
                @(negedge CLOCK);
                tb_rd = 1'b0;
                chk("simul_count", {28'd0, oCount}, 32'd8);
                repeat (HALF - 8) @(negedge CLOCK);
            end else begin
                repeat (HALF) @(negedge CLOCK);
            end
            ps2_clk = 1'b1;
        end
        @(negedge CLOCK);
        ps2_dat = 1'b1;
        repeat (HALF) @(negedge CLOCK);
    endtask

    task automatic send(input logic [7:0] d);
        send_frame(d, 1'b0, 1'b1, 11, 0, -1);
    endtask

    task automatic wait_budget();
        int n;
        n = 0;
        while (rd_budget != 0 && n < 200) begin
            @(negedge CLOCK);
            n++;
        end
        if (rd_budget != 0) chk("budget_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((q.size() != 0 || oValid) && n < 3000) begin
            @(negedge CLOCK);
            n++;
        end
        if (q.size() != 0 || oValid) chk("drain_timeout", q.size(), 32'd0);
    endtask

    initial begin
        RESET   = 1'b1;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        tb_rd   = 1'b0;
        repeat (3) @(negedge CLOCK);
        chk("reset_valid", {31'd0, oValid}, 32'd0);
        chk("reset_data",  {24'd0, oData},  32'd0);
        chk("reset_tag",   {26'd0, oTag},   32'd0);
        chk("reset_count", {28'd0, oCount}, 32'd0);
        RESET = 1'b0;
        repeat (5) @(negedge CLOCK);

        // pop while empty is ignored
        tb_rd = 1'b1;
        @(negedge CLOCK);
        tb_rd = 1'b0;
        @(negedge CLOCK);
        chk("empty_pop_count", {28'd0, oCount}, 32'd0);

        // single frame, exact latency, then pop
        send_frame(8'h1C, 1'b0, 1'b1, 11, 1, -1);
        q.push_back({6'h00, 8'h1C});
        rd_budget = 1;
        wait_budget();
        repeat (2) @(negedge CLOCK);
        chk("pop_valid", {31'd0, oValid}, 32'd0);
        chk("pop_count", {28'd0, oCount}, 32'd0);

        // prefixes and error frames
        rd_budget = 100000;
        q.push_back({6'h03, 8'h74});
        send(8'hE0); send(8'hF0); send(8'h74);
        q.push_back({6'h01, 8'h1C});
        send(8'hF0); send(8'h1C);
        q.push_back({6'h10, 8'h1C});
        send_frame(8'h1C, 1'b1, 1'b1, 11, 0, -1);
        q.push_back({6'h08, 8'h1C});
        send_frame(8'h1C, 1'b0, 1'b0, 11, 0, -1);
        wait_drain();

        // overflow and drop flag
        rd_budget = 0;
        for (int v = 1; v <= 10; v++) begin
            if (v <= 8) q.push_back({6'h00, 8'(v)});
            send(8'(v));
        end
        chk("full_count", {28'd0, oCount}, 32'd8);
        rd_budget = 1;
        wait_budget();
        q.push_back({6'h20, 8'h0B});
        send(8'h0B);
        rd_budget = 100000;
        wait_drain();

        // timeout mid-frame
        send_frame(8'h55, 1'b0, 1'b1, 5, 0, -1);
        repeat (TIMEOUT_CYC + 100) @(negedge CLOCK);
        chk("timeout_valid", {31'd0, oValid}, 32'd0);
        q.push_back({6'h00, 8'h1C});
        send(8'h1C);
        wait_drain();

        // short clock glitch
        @(negedge CLOCK);
        ps2_dat = 1'b0;
        ps2_clk = 1'b0;
        repeat (2) @(negedge CLOCK);
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        repeat (40) @(negedge CLOCK);
        q.push_back({6'h00, 8'h1C});
        send(8'h1C);
        wait_drain();

        // reset mid-frame with entries queued
        rd_budget = 0;
        send(8'h21); send(8'h22); send(8'h23);
        chk("pre_rst_count", {28'd0, oCount}, 32'd3);
        send_frame(8'hFF, 1'b0, 1'b1, 11, 0, 3);
        repeat (TIMEOUT_CYC + 500) @(negedge CLOCK);
        chk("post_rst_valid", {31'd0, oValid}, 32'd0);
        q.push_back({6'h00, 8'h1C});
        rd_budget = 100000;
        send(8'h1C);
        wait_drain();

        // full FIFO with simultaneous push and pop
        rd_budget = 0;
        for (int v = 8'h21; v <= 8'h28; v++) begin
            q.push_back({6'h00, 8'(v)});
            send(8'(v));
        end
        chk("full2_count", {28'd0, oCount}, 32'd8);
        q.push_back({6'h00, 8'h29});
        send_frame(8'h29, 1'b0, 1'b1, 11, 2, -1);
        rd_budget = 100000;
        wait_drain();

        chk("sb_empty", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
